sram_result_arbiter: RTL and testbench
======================================

// Module: sram_result_arbiter
// PURPOSE
//  Shares the single-port result SRAM (17-bit addr, 16-bit data, 1-cycle registered read)
//  between two requesters: port A (processing core) and port B (host readback).
//  Round-robin arbitration, one access per cycle, registered SRAM command, tagged read return.
//  Optional sequencer sweeps the whole memory to zero, replacing the SRAM's own bulk reset.
// PARAMETERS
//  AW  17  address width (2**AW words)
//  DW  16  data width
// PORTS
//  Clk        in   1   clock, all state on rising edge
//  Rst        in   1   reset, asynchronous, active-high
//  a_req      in   1   port A request; held with a_we/a_addr/a_wdata stable until a_gnt
//  a_we       in   1   1=write, 0=read
//  a_addr     in   AW  address
//  a_wdata    in   DW  write data
//  a_gnt      out  1   combinational accept, request consumed this cycle
//  a_rvalid   out  1   read data valid for A (1-cycle pulse)
//  a_rdata    out  DW  read data for A (= mem_rdata)
//  b_*        ---  --  identical set for port B
//  clr_start  in   1   start memory clear (1-cycle pulse)
//  clr_busy   out  1   clear in progress
//  clr_done   out  1   1-cycle pulse after the last clear write is issued
//  mem_en     out  1   SRAM enable (registered)
//  mem_rw     out  1   SRAM RW, 1=write (registered)
//  mem_addr   out  AW  SRAM address (registered)
//  mem_wdata  out  DW  SRAM write data (registered)
//  mem_rdata  in   DW  SRAM Data_Out
// BEHAVIOUR
//  Reset: all outputs and state 0; fsm=ARB; last_grant=B (A wins the first tie).
//    In-flight reads are dropped: no rvalid after reset.
//  ARB state, per cycle:
//    only a_req -> a_gnt; only b_req -> b_gnt;
//    both -> grant the port != last_grant; last_grant updates on every grant.
//  Grant in cycle t -> mem_* driven with that command in t+1 (mem_en=1); otherwise mem_en=0.
//  Read tag: 2-stage pipe {valid, port}. Read granted in t -> SRAM samples at end of t+1
//    -> x_rvalid=1 in t+2, x_rdata=mem_rdata. Write: no response, complete at end of t+1.
//  Throughput: one grant per cycle sustained. Back-to-back reads return in order, one per cycle.
//  A write followed by a read of the same address (any port) returns the new data.
//  gnt is never asserted without the matching req. At most one gnt per cycle.
//  mem_rw/mem_addr/mem_wdata hold their last value when mem_en=0.
// CONFIGURATION
//  SRAM_ARB_CLEAR_EN defined:
//    clr_start in ARB -> no grant that cycle; fsm=CLEAR next cycle.
//    CLEAR: clr_busy=1, no grants; write 0 to addr 0,1,...,2**AW-1, one per cycle.
//    Counter is AW+1 bits, terminates at 2**AW without wrap.
//    After the last write is issued: clr_done=1 for one cycle, clr_busy=0, fsm=ARB.
//    last_grant unchanged across a clear.
//    clr_start during CLEAR is ignored.
//    A read granted just before clr_start still returns rvalid on schedule.
//    Rst during CLEAR aborts to ARB; memory is left partially cleared.
//  SRAM_ARB_CLEAR_EN undefined:
//    Ports remain; clr_start is ignored; clr_busy=0 and clr_done=0 constantly.
//    No CLEAR state or counter logic.
// TESTING
//  1 Reset: Rst high mid-stream -> all outputs 0 at once; a read granted 1 cycle earlier gives no rvalid.
//  2 A write 0x0010<-0xBEEF, then A read 0x0010 -> mem_en high 1 cycle after each gnt;
//    a_rvalid 2 cycles after the read gnt, a_rdata=0xBEEF.
//  3 a_req and b_req held high for 6 cycles after reset -> grants A,B,A,B,A,B;
//    never both in one cycle.
//  4 B reads 0x1FFFF,0x00000,0x00001 back-to-back (preloaded 1,2,3)
//    -> b_rvalid 3 consecutive cycles carrying 1,2,3; a_rvalid stays 0.
//  5 CLEAR_EN, AW=4: write 0x5555 to all 16 addresses, pulse clr_start with a_req high
//    -> 16 zero writes to 0..15; clr_busy 16 cycles; a_gnt 0 throughout;
//    clr_done 1 pulse; A granted next cycle; reads return 0.
//  6 CLEAR_EN undefined: pulse clr_start -> clr_busy/clr_done stay 0; arbitration uninterrupted.

Source files
------------

// File: rtl/sram_result_arbiter.sv
// Round-robin arbiter sharing the single-port result SRAM between port A (core) and port B (host).
// Optional zero-fill sequencer enabled by defining SRAM_ARB_CLEAR_EN.
module sram_result_arbiter #(
    parameter int AW = 17,
    parameter int DW = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic          last_grant_r;
    logic          tag_valid_r;
    logic          tag_port_r;
    logic          a_rvalid_r;
    logic          b_rvalid_r;
    logic          mem_en_r;
    logic          mem_rw_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          arb_en_s;
    logic          a_gnt_s;
    logic          b_gnt_s;
    logic          rd_gnt_s;

`ifdef SRAM_ARB_CLEAR_EN
    typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;
    localparam logic [AW:0] CLR_END = {1'b1, {AW{1'b0}}};

    state_t        state_r;
    logic [AW:0]   clr_cnt_r;
    logic [AW:0]   clr_cnt_nxt_s;
    logic          clr_busy_r;
    logic          clr_done_r;

    assign clr_cnt_nxt_s = clr_cnt_r + {{AW{1'b0}}, 1'b1};
    // A clr_start in ARB steals that cycle; the arbiter is frozen for the whole sweep.
    assign arb_en_s      = !Rst && (state_r == ST_ARB) && !clr_start;
    assign clr_busy      = clr_busy_r;
    assign clr_done      = clr_done_r;

    // Clear sequencer: ARB <-> CLEAR, one zero write per cycle up to the top address
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r    <= ST_ARB;
            clr_cnt_r  <= '0;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= 1'b0;
            case (state_r)
                ST_ARB: begin
                    if (clr_start) begin
                        state_r    <= ST_CLEAR;
                        clr_cnt_r  <= '0;
                        clr_busy_r <= 1'b1;
                    end else begin
                        state_r    <= ST_ARB;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_nxt_s;
                    if (clr_cnt_nxt_s == CLR_END) begin
                        state_r    <= ST_ARB;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        state_r    <= ST_CLEAR;
                    end
                end
                default: begin
                    state_r    <= ST_ARB;
                    clr_busy_r <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_clr_start_s;

    assign unused_clr_start_s = clr_start;
    assign arb_en_s           = !Rst;
    assign clr_busy           = 1'b0;
    assign clr_done           = 1'b0;
`endif

    // Round-robin pick: on a tie the port that was not granted last wins
    always_comb begin
        a_gnt_s = 1'b0;
        b_gnt_s = 1'b0;
        if (arb_en_s) begin
            if (a_req && (!b_req || (last_grant_r == PORT_B))) begin
                a_gnt_s = 1'b1;
            end else if (b_req) begin
                b_gnt_s = 1'b1;
            end else begin
                a_gnt_s = 1'b0;
                b_gnt_s = 1'b0;
            end
        end else begin
            a_gnt_s = 1'b0;
            b_gnt_s = 1'b0;
        end
    end

    assign rd_gnt_s = (a_gnt_s && !a_we) || (b_gnt_s && !b_we);

    // SRAM command register, grant pointer and the two-stage read tag pipe
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_grant_r <= PORT_B;
            tag_valid_r  <= 1'b0;
            tag_port_r   <= PORT_A;
            a_rvalid_r   <= 1'b0;
            b_rvalid_r   <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_rw_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            tag_valid_r <= rd_gnt_s;
            tag_port_r  <= b_gnt_s ? PORT_B : PORT_A;
            a_rvalid_r  <= tag_valid_r && (tag_port_r == PORT_A);
            b_rvalid_r  <= tag_valid_r && (tag_port_r == PORT_B);
            if (a_gnt_s || b_gnt_s) begin
                last_grant_r <= b_gnt_s ? PORT_B : PORT_A;
            end else begin
                last_grant_r <= last_grant_r;
            end
            if (a_gnt_s) begin
                mem_en_r    <= 1'b1;
                mem_rw_r    <= a_we;
                mem_addr_r  <= a_addr;
                mem_wdata_r <= a_wdata;
            end else if (b_gnt_s) begin
                mem_en_r    <= 1'b1;
                mem_rw_r    <= b_we;
                mem_addr_r  <= b_addr;
                mem_wdata_r <= b_wdata;
            end
`ifdef SRAM_ARB_CLEAR_EN
            else if (state_r == ST_CLEAR) begin
                mem_en_r    <= 1'b1;
                mem_rw_r    <= 1'b1;
                mem_addr_r  <= clr_cnt_r[AW-1:0];
                mem_wdata_r <= '0;
            end
`endif
            else begin
                mem_en_r    <= 1'b0;
            end
        end
    end

    assign a_gnt     = a_gnt_s;
    assign b_gnt     = b_gnt_s;
    assign a_rvalid  = a_rvalid_r;
    assign b_rvalid  = b_rvalid_r;
    assign a_rdata   = mem_rdata;
    assign b_rdata   = mem_rdata;
    assign mem_en    = mem_en_r;
    assign mem_rw    = mem_rw_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_sram_result_arbiter.sv
// Self-checking bench for sram_result_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (memory array, response queue, alternating tie-break).
`timescale 1ns/1ps
module tb_sram_result_arbiter;
`ifdef SRAM_ARB_CLEAR_EN
    localparam int AW = 4;
`else
    localparam int AW = 17;
`endif
    localparam int DW  = 16;
    localparam int TOP = (1 << AW) - 1;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic          mem_en, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    sram_result_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port SRAM with one-cycle registered read
    logic [DW-1:0] sram [0:TOP];
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_rw) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0;
        b_req = 1'b0; b_we = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        Rst = 1'b1;
        tick(); tick();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        idle(); Rst = 1'b1; a_req = 1'b1; b_req = 1'b1; #3;
        checks++; if ({a_gnt, b_gnt, mem_en, mem_rw, a_rvalid, b_rvalid, clr_busy, clr_done} !== 8'd0) begin
            failures++; $display("FAIL reset_ctrl got %b want 0", {a_gnt, b_gnt, mem_en, mem_rw, a_rvalid, b_rvalid, clr_busy, clr_done}); end
        checks++; if ({mem_addr, mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_bus got %h want 0", {mem_addr, mem_wdata}); end
        tick(); idle(); tick(); Rst = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = AW'(32'h20); a_wdata = 16'h1234; #3;
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL rst_wr_gnt got %b want 1", a_gnt); end
        tick();
        a_we = 1'b0; #3;
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL rst_rd_gnt got %b want 1", a_gnt); end
        tick();
        idle(); Rst = 1'b1; #1;
        checks++; if ({mem_en, mem_rw, mem_addr, mem_wdata} !== '0) begin
            failures++; $display("FAIL rst_async got %h want 0", {mem_en, mem_rw, mem_addr, mem_wdata}); end
        tick(); Rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rst_drop_rvalid cyc %0d got %b want 0", i, a_rvalid); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        apply_reset();
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = AW'(32'h1); b_addr = AW'(32'h2);
        for (int i = 0; i < 6; i++) begin
            exp_a = (i % 2 == 0);
            #3;
            checks++; if ({a_gnt, b_gnt} !== {exp_a, !exp_a}) begin
                failures++; $display("FAIL rr_grant cyc %0d got %b want %b", i, {a_gnt, b_gnt}, {exp_a, !exp_a}); end
            tick();
        end
        idle(); tick(); tick(); tick();
    endtask

    task automatic test_write_read();
        logic [AW-1:0] addr;
        addr = AW'(32'h10);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = 16'hBEEF; #3;
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got %b want 1", a_gnt); end
        tick();
        a_we = 1'b0; #3;
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL rd_gnt got %b want 1", a_gnt); end
        checks++; if ({mem_en, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b1, addr, 16'hBEEF}) begin
            failures++; $display("FAIL wr_cmd got %h want %h", {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b1, 1'b1, addr, 16'hBEEF}); end
        tick();
        idle(); #3;
        checks++; if ({mem_en, mem_rw, mem_addr} !== {1'b1, 1'b0, addr}) begin
            failures++; $display("FAIL rd_cmd got %h want %h", {mem_en, mem_rw, mem_addr}, {1'b1, 1'b0, addr}); end
        checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rd_early got %b want 0", a_rvalid); end
        tick(); #3;
        checks++; if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 16'hBEEF, 1'b0}) begin
            failures++; $display("FAIL rd_data got %h want %h", {a_rvalid, a_rdata, b_rvalid}, {1'b1, 16'hBEEF, 1'b0}); end
        tick(); #3;
        checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rd_pulse got %b want 0", a_rvalid); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        addrs[0] = AW'(TOP); addrs[1] = AW'(0); addrs[2] = AW'(1);
        for (int i = 0; i < 3; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = addrs[i]; a_wdata = 16'(i + 1); #3;
            checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL b2b_pre_gnt %0d got %b want 1", i, a_gnt); end
            tick();
        end
        idle(); tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin b_req = 1'b1; b_we = 1'b0; b_addr = addrs[i]; end
            else idle();
            #3;
            if (i < 3) begin
                checks++; if (b_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt %0d got %b want 1", i, b_gnt); end
            end
            checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_a_rvalid %0d got %b want 0", i, a_rvalid); end
            if (i >= 2) begin
                checks++; if ({b_rvalid, b_rdata} !== {1'b1, 16'(i - 1)}) begin
                    failures++; $display("FAIL b2b_data %0d got %h want %h", i, {b_rvalid, b_rdata}, {1'b1, 16'(i - 1)}); end
            end else begin
                checks++; if (b_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_early %0d got %b want 0", i, b_rvalid); end
            end
            tick();
        end
    endtask

    typedef struct {
        int            due;
        logic          port;
        logic [DW-1:0] data;
    } resp_t;

    task automatic test_random();
        resp_t         rq [$];
        resp_t         r;
        logic [DW-1:0] ref_mem [8];
        logic          ref_last_b;
        logic          a_pend, b_pend, exp_a, exp_b;
        logic          cmd_v, cmd_rw;
        logic [AW-1:0] cmd_addr;
        logic [DW-1:0] cmd_wdata;
        apply_reset();
        ref_last_b = 1'b1; a_pend = 1'b0; b_pend = 1'b0; cmd_v = 1'b0;
        cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!a_pend) begin
                if (cyc < 8) begin
                    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(cyc); a_wdata = 16'($urandom);
                end else if ($urandom_range(0, 3) != 0) begin
                    a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                    a_addr = AW'($urandom_range(0, 7)); a_wdata = 16'($urandom);
                end else a_req = 1'b0;
            end
            if (!b_pend) begin
                if (cyc >= 8 && $urandom_range(0, 3) != 0) begin
                    b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                    b_addr = AW'($urandom_range(0, 7)); b_wdata = 16'($urandom);
                end else b_req = 1'b0;
            end
            a_pend = a_req; b_pend = b_req;
            #3;
            exp_a = a_req && (!b_req || ref_last_b);
            exp_b = b_req && !exp_a;
            checks++; if ({a_gnt, b_gnt} !== {exp_a, exp_b}) begin
                failures++; $display("FAIL rnd_gnt cyc %0d got %b want %b", cyc, {a_gnt, b_gnt}, {exp_a, exp_b}); end
            checks++;
            if (cmd_v) begin
                if ({mem_en, mem_rw, mem_addr} !== {1'b1, cmd_rw, cmd_addr} || (cmd_rw && mem_wdata !== cmd_wdata)) begin
                    failures++; $display("FAIL rnd_cmd cyc %0d got %h want %h", cyc, {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b1, cmd_rw, cmd_addr, cmd_wdata}); end
            end else if (mem_en !== 1'b0) begin
                failures++; $display("FAIL rnd_idle cyc %0d got %b want 0", cyc, mem_en);
            end
            checks++;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                if ({a_rvalid, b_rvalid} !== {!r.port, r.port} || (r.port ? b_rdata : a_rdata) !== r.data) begin
                    failures++; $display("FAIL rnd_resp cyc %0d got %b/%h/%h want %b/%h", cyc, {a_rvalid, b_rvalid}, a_rdata, b_rdata, {!r.port, r.port}, r.data); end
            end else if ({a_rvalid, b_rvalid} !== 2'b00) begin
                failures++; $display("FAIL rnd_spurious cyc %0d got %b want 00", cyc, {a_rvalid, b_rvalid});
            end
            cmd_v = exp_a || exp_b;
            if (exp_a || exp_b) begin
                cmd_rw    = exp_a ? a_we : b_we;
                cmd_addr  = exp_a ? a_addr : b_addr;
                cmd_wdata = exp_a ? a_wdata : b_wdata;
                ref_last_b = exp_b;
                if (cmd_rw) ref_mem[cmd_addr[2:0]] = cmd_wdata;
                else rq.push_back('{cyc + 2, exp_b, ref_mem[cmd_addr[2:0]]});
                if (exp_a) a_pend = 1'b0;
                else       b_pend = 1'b0;
            end
            tick();
        end
        idle(); tick(); tick(); tick();
    endtask

`ifdef SRAM_ARB_CLEAR_EN
    task automatic test_clear();
        apply_reset();
        for (int i = 0; i <= TOP; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = AW'(i); a_wdata = 16'h5555; #3;
            checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL clr_pre_gnt %0d got %b want 1", i, a_gnt); end
            tick();
        end
        a_we = 1'b0; a_addr = AW'(2); #3;
        checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL clr_rd_gnt got %b want 1", a_gnt); end
        tick();
        a_addr = AW'(3); clr_start = 1'b1; #3;
        checks++; if ({a_gnt, clr_busy} !== 2'b00) begin failures++; $display("FAIL clr_start_cyc got %b want 00", {a_gnt, clr_busy}); end
        tick();
        for (int k = 0; k <= TOP + 1; k++) begin
            clr_start = (k == 5);
            #3;
            if (k <= TOP) begin
                checks++; if ({clr_busy, clr_done, a_gnt} !== 3'b100) begin
                    failures++; $display("FAIL clr_busy k %0d got %b want 100", k, {clr_busy, clr_done, a_gnt}); end
            end else begin
                checks++; if ({clr_busy, clr_done, a_gnt} !== 3'b011) begin
                    failures++; $display("FAIL clr_done k %0d got %b want 011", k, {clr_busy, clr_done, a_gnt}); end
            end
            if (k == 0) begin
                checks++; if ({mem_en, a_rvalid, a_rdata} !== {1'b0, 1'b1, 16'h5555}) begin
                    failures++; $display("FAIL clr_inflight got %h want %h", {mem_en, a_rvalid, a_rdata}, {1'b0, 1'b1, 16'h5555}); end
            end else begin
                checks++; if ({mem_en, mem_rw, mem_addr, mem_wdata} !== {1'b1, 1'b1, AW'(k - 1), 16'h0000}) begin
                    failures++; $display("FAIL clr_write k %0d got %h want %h", k, {mem_en, mem_rw, mem_addr, mem_wdata}, {1'b1, 1'b1, AW'(k - 1), 16'h0000}); end
            end
            tick();
        end
        idle(); #3;
        checks++; if ({clr_busy, clr_done} !== 2'b00) begin failures++; $display("FAIL clr_after got %b want 00", {clr_busy, clr_done}); end
        tick();
        for (int i = 0; i <= TOP + 2; i++) begin
            if (i <= TOP) begin a_req = 1'b1; a_we = 1'b0; a_addr = AW'(i); end
            else idle();
            #3;
            if (i >= 2) begin
                checks++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h0000}) begin
                    failures++; $display("FAIL clr_readback %0d got %h want %h", i - 2, {a_rvalid, a_rdata}, {1'b1, 16'h0000}); end
            end
            tick();
        end
    endtask
`else
    task automatic test_no_clear();
        a_req = 1'b1; a_we = 1'b0; a_addr = AW'(5);
        for (int i = 0; i < 4; i++) begin
            clr_start = (i == 1);
            #3;
            checks++; if ({a_gnt, clr_busy, clr_done} !== 3'b100) begin
                failures++; $display("FAIL noclr %0d got %b want 100", i, {a_gnt, clr_busy, clr_done}); end
            tick();
        end
        idle(); tick(); tick();
    endtask
`endif

    initial begin
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        idle();
        Rst = 1'b1;
        test_reset();
        test_round_robin();
        test_write_read();
        test_back_to_back();
        test_random();
`ifdef SRAM_ARB_CLEAR_EN
        test_clear();
`else
        test_no_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
